// File: rtl/mcd_alloc_pkg.sv
// Shared field layout, opcodes and FSM states for the memcached block allocator.
// Also provides the response-word packer used by the top level.
package mcd_alloc_pkg;

    localparam int REQ_WID      = 57;
    localparam int REQ_ADDR_LSB = 0;
    localparam int REQ_ADDR_WID = 32;
    localparam int REQ_SIZE_LSB = 32;
    localparam int REQ_SIZE_WID = 24;
    localparam int REQ_OP_BIT   = 56;

    localparam int RET_WID      = 40;
    localparam int RET_ADDR_LSB = 0;
    localparam int RET_OK_BIT   = 32;
    localparam int RET_OP_BIT   = 33;

    localparam logic OP_ALLOC = 1'b0;
    localparam logic OP_FREE  = 1'b1;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RESP = 2'd2
    } state_t;

    // Reserved response bits stay zero because the word starts cleared.
    function automatic logic [RET_WID-1:0] pack_ret(input logic [31:0] addr,
                                                    input logic        ok,
                                                    input logic        op);
        logic [RET_WID-1:0] word;
        word                          = '0;
        word[RET_ADDR_LSB +: 32]      = addr;
        word[RET_OK_BIT]              = ok;
        word[RET_OP_BIT]              = op;
        return word;
    endfunction

endpackage

// File: rtl/mcd_freelist_fifo.sv
// Free-list FIFO of block indices: 1R1W RAM with registered read, head/tail pointers
// and an occupancy count that tells full from empty.
module mcd_freelist_fifo #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [AW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [AW-1:0] o_rdata,
    output logic [AW:0]   o_count
);

    logic [AW-1:0] r_ram [DEPTH];
    logic [AW-1:0] r_rdata;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    // RAM has no reset so it maps onto block RAM; contents are rebuilt after reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_ram[r_tail] <= i_wdata;
        end
        if (i_pop) begin
            r_rdata <= r_ram[r_head];
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + AW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_count = r_count;

endmodule

// File: rtl/mcd_block_allocator.sv
// Fixed-size DRAM block allocator: one request in flight, free-list FIFO for indices,
// allocated bitmap to reject frees of blocks that are not currently handed out.
module mcd_block_allocator
    import mcd_alloc_pkg::*;
#(
    parameter  int          NUM_BLOCKS  = 1024,
    parameter  int          BLOCK_SHIFT = 12,
    parameter  logic [31:0] BASE_ADDR   = 32'h4000_0000,
    localparam int          IDX_WID     = $clog2(NUM_BLOCKS)
) (
    input  logic                 apclk,
    input  logic                 apresetn,
    input  logic [REQ_WID-1:0]   alloc_tdata,
    input  logic                 alloc_tvalid,
    output logic                 alloc_tready,
    output logic [RET_WID-1:0]   alloc_ret_tdata,
    output logic                 alloc_ret_tvalid,
    input  logic                 alloc_ret_tready,
    output logic [IDX_WID:0]     free_count,
    output logic                 init_done
);

    localparam logic [31:0] BLOCK_BYTES  = 32'd1 << BLOCK_SHIFT;
    localparam logic [31:0] NUM_BLOCKS_W = 32'(NUM_BLOCKS);

    state_t                  r_state;
    logic [IDX_WID-1:0]      r_init_idx;
    logic [NUM_BLOCKS-1:0]   r_bitmap;
    logic                    r_tready;
    logic                    r_init_done;
    logic                    r_ret_valid;
    logic [RET_WID-1:0]      r_ret_data;
    logic                    r_pend_ok;
    logic                    r_pend_op;
    logic [31:0]             r_pend_addr;

    logic [31:0]             w_req_addr;
    logic [REQ_SIZE_WID-1:0] w_req_size;
    logic                    w_req_op;
    logic                    w_accept;
    logic [31:0]             w_off;
    logic [31:0]             w_blk;
    logic [IDX_WID-1:0]      w_free_idx;
    logic                    w_alloc_ok;
    logic                    w_free_ok;
    logic                    w_push;
    logic                    w_pop;
    logic [IDX_WID-1:0]      w_wdata;
    logic [IDX_WID-1:0]      w_rdata;
    logic [IDX_WID:0]        w_count;
    logic [31:0]             w_alloc_addr;
    logic [31:0]             w_resp_addr;

    assign w_req_addr = alloc_tdata[REQ_ADDR_LSB +: REQ_ADDR_WID];
    assign w_req_size = alloc_tdata[REQ_SIZE_LSB +: REQ_SIZE_WID];
    assign w_req_op   = alloc_tdata[REQ_OP_BIT];
    assign w_accept   = alloc_tvalid && r_tready;

    // Offset wraps for addresses below base; the explicit >= check rejects those.
    assign w_off      = w_req_addr - BASE_ADDR;
    assign w_blk      = w_off >> BLOCK_SHIFT;
    assign w_free_idx = w_off[BLOCK_SHIFT +: IDX_WID];

    assign w_alloc_ok = (w_req_size != '0) && (32'(w_req_size) <= BLOCK_BYTES) && (w_count != '0);
    assign w_free_ok  = (w_req_addr >= BASE_ADDR) && (w_blk < NUM_BLOCKS_W) &&
                        (w_off[BLOCK_SHIFT-1:0] == '0) && r_bitmap[w_free_idx];

    assign w_push  = (r_state == INIT) || (w_accept && (w_req_op == OP_FREE) && w_free_ok);
    assign w_pop   = w_accept && (w_req_op == OP_ALLOC) && w_alloc_ok;
    assign w_wdata = (r_state == INIT) ? r_init_idx : w_free_idx;

    mcd_freelist_fifo #(
        .DEPTH (NUM_BLOCKS)
    ) u_freelist (
        .clk     (apclk),
        .i_rst_n (apresetn),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (w_count)
    );

    assign w_alloc_addr = BASE_ADDR + (32'(w_rdata) << BLOCK_SHIFT);
    assign w_resp_addr  = (r_pend_op == OP_FREE) ? r_pend_addr :
                          (r_pend_ok ? w_alloc_addr : 32'd0);

    // First RESP cycle (r_ret_valid=0) waits for the popped index from the RAM.
    always_ff @(posedge apclk) begin
        if (!apresetn) begin
            r_state     <= INIT;
            r_init_idx  <= '0;
            r_bitmap    <= '0;
            r_tready    <= 1'b0;
            r_init_done <= 1'b0;
            r_ret_valid <= 1'b0;
            r_ret_data  <= '0;
            r_pend_ok   <= 1'b0;
            r_pend_op   <= 1'b0;
            r_pend_addr <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    r_init_idx <= r_init_idx + IDX_WID'(1);
                    if (r_init_idx == '1) begin
                        r_state     <= IDLE;
                        r_init_done <= 1'b1;
                        r_tready    <= 1'b1;
                    end
                end
                IDLE: begin
                    if (w_accept) begin
                        r_pend_op   <= w_req_op;
                        r_pend_ok   <= (w_req_op == OP_FREE) ? w_free_ok : w_alloc_ok;
                        r_pend_addr <= w_req_addr;
                        r_tready    <= 1'b0;
                        r_state     <= RESP;
                        if ((w_req_op == OP_FREE) && w_free_ok) begin
                            r_bitmap[w_free_idx] <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    if (!r_ret_valid) begin
                        r_ret_valid <= 1'b1;
                        r_ret_data  <= pack_ret(w_resp_addr, r_pend_ok, r_pend_op);
                        if ((r_pend_op == OP_ALLOC) && r_pend_ok) begin
                            r_bitmap[w_rdata] <= 1'b1;
                        end
                    end else if (alloc_ret_tready) begin
                        r_ret_valid <= 1'b0;
                        r_tready    <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    assign alloc_tready     = r_tready;
    assign alloc_ret_tvalid = r_ret_valid;
    assign alloc_ret_tdata  = r_ret_data;
    assign free_count       = w_count;
    assign init_done        = r_init_done;

endmodule

// File: tb/tb_mcd_block_allocator.sv
// Randomised scoreboard bench for mcd_block_allocator: a queue/array reference model
// predicts every response; a monitor pops and compares whenever a response is consumed.
module tb_mcd_block_allocator;

    localparam int          N     = 1024;
    localparam int          BLK   = 4096;
    localparam logic [31:0] BASE  = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        apresetn = 1'b0;
    logic [56:0] alloc_tdata = '0;
    logic        alloc_tvalid = 1'b0;
    logic        alloc_tready;
    logic [39:0] ret_tdata;
    logic        ret_tvalid;
    logic        ret_tready = 1'b0;
    logic [10:0] free_count;
    logic        init_done;

    mcd_block_allocator #(
        .NUM_BLOCKS  (N),
        .BLOCK_SHIFT (12),
        .BASE_ADDR   (BASE)
    ) dut (
        .apclk            (clk),
        .apresetn         (apresetn),
        .alloc_tdata      (alloc_tdata),
        .alloc_tvalid     (alloc_tvalid),
        .alloc_tready     (alloc_tready),
        .alloc_ret_tdata  (ret_tdata),
        .alloc_ret_tvalid (ret_tvalid),
        .alloc_ret_tready (ret_tready),
        .free_count       (free_count),
        .init_done        (init_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          issued   = 0;
    int          rsp_seen = 0;
    int          bp_mode  = 0;
    logic [39:0] exp_q[$];
    int          fl[$];
    int          live[$];
    bit          amap[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        live.delete();
        for (int i = 0; i < N; i++) begin
            fl.push_back(i);
            amap[i] = 1'b0;
        end
    endtask

    // Reference: blocks are handed out in free-list order, addresses are plain arithmetic.
    task automatic model_req(input bit op, input logic [31:0] addr, input int size,
                             output logic [39:0] expv);
        longint      off;
        int          idx;
        bit          ok;
        logic [31:0] raddr;
        ok    = 1'b0;
        raddr = 32'd0;
        if (!op) begin
            if (size >= 1 && size <= BLK && fl.size() > 0) begin
                idx = fl.pop_front();
                amap[idx] = 1'b1;
                live.push_back(idx);
                raddr = 32'(longint'(BASE) + longint'(idx) * BLK);
                ok = 1'b1;
            end
        end else begin
            raddr = addr;
            off = longint'(addr) - longint'(BASE);
            if (off >= 0 && off < longint'(N) * BLK && (off % BLK) == 0) begin
                idx = int'(off / BLK);
                if (amap[idx]) begin
                    ok = 1'b1;
                    amap[idx] = 1'b0;
                    fl.push_back(idx);
                    for (int k = 0; k < live.size(); k++) begin
                        if (live[k] == idx) begin
                            live.delete(k);
                            break;
                        end
                    end
                end
            end
        end
        expv = {6'b0, op, ok, raddr};
    endtask

    task automatic send_req(input bit op, input logic [31:0] addr, input logic [23:0] size);
        logic [39:0] e;
        bit          got;
        @(posedge clk);
        #1;
        alloc_tdata  = {op, size, addr};
        alloc_tvalid = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (alloc_tready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fails++;
            $display("FAIL accept_timeout: actual=tready_low required=accept_within_200");
            alloc_tvalid = 1'b0;
            return;
        end
        model_req(op, addr, int'(size), e);
        exp_q.push_back(e);
        issued++;
        @(posedge clk);
        #1;
        alloc_tvalid = 1'b0;
        alloc_tdata  = 57'({$urandom(), $urandom()});
        check("tready_drop", 64'(alloc_tready), 64'(0));
        check("lat_early", 64'(ret_tvalid), 64'(0));
        @(posedge clk);
        #1;
        check("lat_valid", 64'(ret_tvalid), 64'(1));
    endtask

    task automatic wait_rsp();
        int c;
        c = 0;
        while (rsp_seen < issued && c < 2000) begin
            @(posedge clk);
            #2;
            c++;
        end
        if (rsp_seen < issued) begin
            n_checks++;
            n_fails++;
            $display("FAIL rsp_timeout: actual=%0d required=%0d", rsp_seen, issued);
            rsp_seen = issued;
            exp_q.delete();
        end
        check("free_count", 64'(free_count), 64'(fl.size()));
    endtask

    task automatic do_req(input bit op, input logic [31:0] addr, input logic [23:0] size);
        send_req(op, addr, size);
        wait_rsp();
    endtask

    task automatic wait_init(output int edges, output int early_ready);
        edges = 0;
        early_ready = 0;
        while (!init_done && edges < 3000) begin
            @(posedge clk);
            #1;
            edges++;
            if (!init_done && alloc_tready) early_ready++;
        end
    endtask

    // Monitor: a response is consumed at the posedge following a negedge with valid&&ready.
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (apresetn && ret_tvalid && ret_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_rsp: actual=0x%0h required=no_response", ret_tdata);
                end else begin
                    e = exp_q.pop_front();
                    $display("rsp op=%0d ok=%0d addr=0x%08h", ret_tdata[33], ret_tdata[32], ret_tdata[31:0]);
                    check("rsp_data", 64'(ret_tdata), 64'(e));
                end
                rsp_seen++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       ret_tready = 1'b1;
                1:       ret_tready = 1'($urandom_range(0, 1));
                default: ret_tready = 1'b0;
            endcase
        end
    end

    initial begin
        int          edges;
        int          early;
        logic [39:0] snap;
        logic [39:0] dropped;
        int          r;
        logic [31:0] a;

        model_reset();
        // T1: reset state and init duration
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 64'(alloc_tready), 64'(0));
        check("rst_tvalid", 64'(ret_tvalid), 64'(0));
        check("rst_tdata", 64'(ret_tdata), 64'(0));
        check("rst_count", 64'(free_count), 64'(0));
        check("rst_init_done", 64'(init_done), 64'(0));
        apresetn = 1'b1;
        wait_init(edges, early);
        check("init_edges", 64'(edges), 64'(N));
        check("init_early_ready", 64'(early), 64'(0));
        check("init_count", 64'(free_count), 64'(N));
        check("init_tready", 64'(alloc_tready), 64'(1));

        // T2: first allocations
        do_req(1'b0, 32'h0, 24'd64);
        do_req(1'b0, 32'h0, 24'd64);
        check("t2_count", 64'(free_count), 64'(N - 2));

        // T3: exhaust, fail, free and reuse
        for (int i = 2; i < N; i++) do_req(1'b0, 32'h0, 24'($urandom_range(1, BLK)));
        check("t3_empty", 64'(free_count), 64'(0));
        do_req(1'b0, 32'h0, 24'd1);
        do_req(1'b1, 32'h4000_3000, 24'd0);
        do_req(1'b0, 32'h0, 24'd4096);

        // T4: malformed requests leave the count alone
        do_req(1'b1, 32'h4000_5000, 24'd0);
        do_req(1'b0, 32'h0, 24'd0);
        do_req(1'b0, 32'h0, 24'd4097);
        do_req(1'b1, 32'h4000_0800, 24'd0);
        do_req(1'b1, 32'h3FFF_F000, 24'd0);
        do_req(1'b1, 32'h4040_0000, 24'd0);
        do_req(1'b1, 32'h4000_5000, 24'd0);
        check("t4_count", 64'(free_count), 64'(1));

        // T5: response held under backpressure
        bp_mode = 2;
        @(posedge clk);
        #2;
        send_req(1'b0, 32'h0, 24'd100);
        snap = ret_tdata;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("t5_hold", 64'({ret_tvalid, alloc_tready, ret_tdata}), 64'({1'b1, 1'b0, snap}));
        end
        bp_mode = 0;
        wait_rsp();
        do_req(1'b1, snap[31:0], 24'd0);

        // Randomised traffic with random response backpressure
        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3 || (r <= 7 && r >= 5 && live.size() == 0)) begin
                do_req(1'b0, 32'($urandom()), 24'($urandom_range(1, BLK)));
            end else if (r == 4) begin
                do_req(1'b0, 32'h0, ($urandom_range(0, 1) == 1) ? 24'd0 : 24'(BLK + 1 + $urandom_range(0, 5000)));
            end else if (r <= 7) begin
                a = 32'(longint'(BASE) + longint'(live[$urandom_range(0, live.size() - 1)]) * BLK);
                do_req(1'b1, a, 24'($urandom()));
            end else if (r == 8) begin
                a = BASE - 32'h1_0000 + 32'($urandom_range(0, N * BLK + 32'h2_0000));
                if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_F000;
                do_req(1'b1, a, 24'd0);
            end else begin
                a = BASE + 32'($urandom_range(0, N - 1)) * 32'(BLK);
                do_req(1'b1, a, 24'd0);
            end
        end

        // T6: reset while a response is pending
        bp_mode = 2;
        @(posedge clk);
        #2;
        send_req(1'b0, 32'h0, 24'd8);
        dropped = exp_q[exp_q.size() - 1];
        @(posedge clk);
        #1;
        apresetn = 1'b0;
        @(posedge clk);
        #1;
        check("t6_tvalid", 64'(ret_tvalid), 64'(0));
        check("t6_tdata", 64'(ret_tdata), 64'(0));
        check("t6_count", 64'(free_count), 64'(0));
        exp_q.delete();
        rsp_seen = issued;
        model_reset();
        bp_mode = 0;
        apresetn = 1'b1;
        wait_init(edges, early);
        check("t6_init_edges", 64'(edges), 64'(N));
        check("t6_init_count", 64'(free_count), 64'(N));
        if (dropped[32]) begin
            do_req(1'b1, dropped[31:0], 24'd0);
        end
        do_req(1'b1, BASE, 24'd0);
        do_req(1'b0, 32'h0, 24'd4096);

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
